// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: memory op codes, FSM states and access-size decode shared by the control unit and the LSU.
package mem_lsu_pkg;
   localparam logic [2:0] LD_B  = 3'b000;
   localparam logic [2:0] LD_H  = 3'b001;
   localparam logic [2:0] LD_W  = 3'b010;
   localparam logic [2:0] LD_BU = 3'b011;
   localparam logic [2:0] LD_HU = 3'b100;
   localparam logic [1:0] ST_B  = 2'b00;
   localparam logic [1:0] ST_H  = 2'b01;
   localparam logic [1:0] ST_W  = 2'b10;

   typedef enum logic [2:0] {S_IDLE, S_ACC0, S_ACC1, S_RESP, S_ERR} state_t;

   // Size in bytes; 0 marks a reserved code.
   function automatic logic [2:0] op_size(input logic we, input logic [2:0] ld, input logic [1:0] st);
      if (we)
         return (st == ST_B) ? 3'd1 : (st == ST_H) ? 3'd2 : (st == ST_W) ? 3'd4 : 3'd0;
      return (ld == LD_B || ld == LD_BU) ? 3'd1 :
             (ld == LD_H || ld == LD_HU) ? 3'd2 :
             (ld == LD_W) ? 3'd4 : 3'd0;
   endfunction
endpackage

// File: rtl/mem_lsu_align.sv
// lsu_align: byte-enable generation, store lane steering and load extraction/extension.
// MISALIGN_SPLIT_EN adds the second-beat outputs; otherwise spilling or odd halfword accesses flag an error.
module lsu_align
   import mem_lsu_pkg::*;
(
`ifdef MISALIGN_SPLIT_EN
   input  logic [31:0] i_rdata1,
   output logic [3:0]  o_be1,
   output logic [31:0] o_wdata1,
   output logic        o_spill,
`endif
   input  logic        i_we,
   input  logic [2:0]  i_load,
   input  logic [1:0]  i_store,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata0,
   output logic [3:0]  o_be0,
   output logic [31:0] o_wdata0,
   output logic [31:0] o_rdata,
   output logic        o_err
);
   logic [2:0]  w_size;
   logic [7:0]  w_be;
   logic [31:0] w_rb;

   assign w_size = op_size(i_we, i_load, i_store);
   // Upper nibble of the shifted mask is exactly the beat-1 byte enables.
   assign w_be   = ((8'd1 << w_size) - 8'd1) << i_off;

`ifdef MISALIGN_SPLIT_EN
   assign {o_wdata1, o_wdata0} = {32'd0, i_wdata} << {i_off, 3'b000};
   assign {o_be1, o_be0}       = w_be;
   assign w_rb    = 32'({i_rdata1, i_rdata0} >> {i_off, 3'b000});
   assign o_spill = |w_be[7:4];
   assign o_err   = w_size == 3'd0;
`else
   assign o_wdata0 = i_wdata << {i_off, 3'b000};
   assign o_be0    = w_be[3:0];
   assign w_rb     = i_rdata0 >> {i_off, 3'b000};
   assign o_err    = w_size == 3'd0 || |w_be[7:4] || (w_size == 3'd2 && i_off[0]);
`endif

   assign o_rdata = i_we ? 32'd0 :
                    (i_load == LD_B)  ? {{24{w_rb[7]}}, w_rb[7:0]} :
                    (i_load == LD_H)  ? {{16{w_rb[15]}}, w_rb[15:0]} :
                    (i_load == LD_BU) ? {24'd0, w_rb[7:0]} :
                    (i_load == LD_HU) ? {16'd0, w_rb[15:0]} : w_rb;
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit turning core memory ops into req/ack bus beats and extended load results.
// MISALIGN_SPLIT_EN enables two-beat execution of accesses that cross a word boundary.
module mem_lsu
   import mem_lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              mem_write,
   input  logic [2:0]        load,
   input  logic [1:0]        store,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              stall,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_be,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_ack,
   input  logic [DATA_W-1:0] bus_rdata
);
   state_t            r_state;
   logic              r_we, r_ready, r_stall, r_resp_valid, r_resp_err, r_bus_req, r_bus_we;
   logic [2:0]        r_load;
   logic [1:0]        r_store, r_off;
   logic [DATA_W-1:0] r_wdata, r_resp_rdata, r_bus_wdata;
   logic [ADDR_W-1:0] r_bus_addr;
   logic [3:0]        r_bus_be;
   logic              w_idle, w_we, w_err;
   logic [2:0]        w_load;
   logic [1:0]        w_store, w_off;
   logic [DATA_W-1:0] w_wdata, w_wdata0, w_rdata, w_rdata0;
   logic [3:0]        w_be0;
`ifdef MISALIGN_SPLIT_EN
   logic [DATA_W-1:0] r_rdata0, w_wdata1;
   logic [3:0]        w_be1;
   logic              w_spill;
`endif

   // In IDLE the aligner looks at the incoming op so beat 0 can be registered at accept.
   assign w_idle  = r_state == S_IDLE;
   assign w_we    = w_idle ? mem_write : r_we;
   assign w_load  = w_idle ? load : r_load;
   assign w_store = w_idle ? store : r_store;
   assign w_off   = w_idle ? addr[1:0] : r_off;
   assign w_wdata = w_idle ? wdata : r_wdata;
`ifdef MISALIGN_SPLIT_EN
   assign w_rdata0 = (r_state == S_ACC1) ? r_rdata0 : bus_rdata;
`else
   assign w_rdata0 = bus_rdata;
`endif

   lsu_align u_align (
`ifdef MISALIGN_SPLIT_EN
      .i_rdata1 (bus_rdata),
      .o_be1    (w_be1),
      .o_wdata1 (w_wdata1),
      .o_spill  (w_spill),
`endif
      .i_we     (w_we),
      .i_load   (w_load),
      .i_store  (w_store),
      .i_off    (w_off),
      .i_wdata  (w_wdata),
      .i_rdata0 (w_rdata0),
      .o_be0    (w_be0),
      .o_wdata0 (w_wdata0),
      .o_rdata  (w_rdata),
      .o_err    (w_err)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_we         <= 1'b0;
         r_load       <= '0;
         r_store      <= '0;
         r_off        <= '0;
         r_wdata      <= '0;
         r_ready      <= 1'b1;
         r_stall      <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= '0;
         r_bus_req    <= 1'b0;
         r_bus_we     <= 1'b0;
         r_bus_addr   <= '0;
         r_bus_be     <= '0;
         r_bus_wdata  <= '0;
`ifdef MISALIGN_SPLIT_EN
         r_rdata0     <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: if (req_valid) begin
               r_we    <= mem_write;
               r_load  <= load;
               r_store <= store;
               r_off   <= addr[1:0];
               r_wdata <= wdata;
               r_ready <= 1'b0;
               r_stall <= 1'b1;
               if (w_err) begin
                  r_state      <= S_ERR;
                  r_resp_valid <= 1'b1;
                  r_resp_err   <= 1'b1;
               end else begin
                  r_state     <= S_ACC0;
                  r_bus_req   <= 1'b1;
                  r_bus_we    <= mem_write;
                  r_bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                  r_bus_be    <= w_be0;
                  r_bus_wdata <= w_wdata0;
               end
            end
            S_ACC0: if (r_bus_req && bus_ack) begin
               r_bus_req <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
               if (w_spill) begin
                  r_state     <= S_ACC1;
                  r_rdata0    <= bus_rdata;
                  r_bus_addr  <= r_bus_addr + ADDR_W'(4);
                  r_bus_be    <= w_be1;
                  r_bus_wdata <= w_wdata1;
               end else
`endif
               begin
                  r_state      <= S_RESP;
                  r_resp_valid <= 1'b1;
                  r_resp_rdata <= w_rdata;
               end
            end
`ifdef MISALIGN_SPLIT_EN
            // Beat 1 starts with req low for one cycle so beats never run back to back.
            S_ACC1: if (!r_bus_req) r_bus_req <= 1'b1;
            else if (bus_ack) begin
               r_bus_req    <= 1'b0;
               r_state      <= S_RESP;
               r_resp_valid <= 1'b1;
               r_resp_rdata <= w_rdata;
            end
`endif
            S_RESP, S_ERR: begin
               r_state      <= S_IDLE;
               r_ready      <= 1'b1;
               r_stall      <= 1'b0;
               r_resp_valid <= 1'b0;
               r_resp_err   <= 1'b0;
               r_resp_rdata <= '0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign req_ready  = r_ready;
   assign stall      = r_stall;
   assign resp_valid = r_resp_valid;
   assign resp_err   = r_resp_err;
   assign resp_rdata = r_resp_rdata;
   assign bus_req    = r_bus_req;
   assign bus_we     = r_bus_we;
   assign bus_addr   = r_bus_addr;
   assign bus_be     = r_bus_be;
   assign bus_wdata  = r_bus_wdata;
endmodule
